// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder: one BLOCK-bit CLA slice per stage, carry registered
// between stages, operands skewed in and slice sums deskewed out so one op leaves whole.
module cla_adder_pipe #(
  parameter int WIDTH = 64,
  parameter int BLOCK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTG = WIDTH / BLOCK;

  if ((BLOCK < 4) || (WIDTH < BLOCK) || ((WIDTH % BLOCK) != 0) || ((BLOCK % 4) != 0)) begin : g_bad_param
    $error("cla_adder_pipe: WIDTH (%0d) must be a multiple of BLOCK (%0d) and BLOCK a multiple of 4",
           WIDTH, BLOCK);
  end

  // One BLOCK-bit slice built from 4-bit generate/propagate lookahead groups.
  function automatic logic [BLOCK:0] cla_slice(input logic [BLOCK-1:0] x,
                                               input logic [BLOCK-1:0] y,
                                               input logic             ci);
    logic [BLOCK-1:0] g, p, s;
    logic [3:0]       gg, pp;
    logic [4:0]       cc;
    logic             c;
    g = x & y;
    p = x ^ y;
    s = '0;
    c = ci;
    for (int j = 0; j < BLOCK / 4; j++) begin
      gg    = g[4*j +: 4];
      pp    = p[4*j +: 4];
      cc[0] = c;
      cc[1] = gg[0] | (pp[0] & c);
      cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c);
      cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | ((&pp[2:0]) & c);
      cc[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | ((&pp[3:1]) & gg[0])
            | ((&pp) & c);
      s[4*j +: 4] = pp ^ cc[3:0];
      c = cc[4];
    end
    return {c, s};
  endfunction

  // Handshake: a transfer happens on an edge where valid && ready. The whole pipe
  // freezes only while a finished result waits (out_valid && !out_ready); in_ready is
  // exactly the inverse of that stall, so out_ready reaches nothing else.
  logic stall, en;
  assign stall    = out_valid & ~out_ready;
  assign en       = ~stall;
  assign in_ready = en;

  logic             iv, ic;
  logic [WIDTH-1:0] ia, ib;

  always_ff @(posedge clk) begin
    if (rst) begin
      iv <= 1'b0;
      ia <= '0;
      ib <= '0;
      ic <= 1'b0;
    end else if (en) begin
      iv <= in_valid;
      ia <= a;
      ib <= b;
      ic <= cin;
    end
  end

  for (genvar k = 0; k < NSTG; k++) begin : stg
    localparam int RW = WIDTH - k * BLOCK;  // operand bits not yet summed

    logic [RW-1:0]          xa, xb;
    logic                   xv, xc, xam, xbm;
    logic [BLOCK:0]         slice;
    logic [(k+1)*BLOCK-1:0] s_nx, s_q;
    logic                   v_q, c_q;

    if (k == 0) begin : g_src
      assign xa   = ia;
      assign xb   = ib;
      assign xv   = iv;
      assign xc   = ic;
      assign xam  = ia[WIDTH-1];
      assign xbm  = ib[WIDTH-1];
      assign s_nx = slice[BLOCK-1:0];
    end else begin : g_src
      assign xa   = stg[k-1].g_rem.ra_q;
      assign xb   = stg[k-1].g_rem.rb_q;
      assign xv   = stg[k-1].v_q;
      assign xc   = stg[k-1].c_q;
      assign xam  = stg[k-1].g_rem.am_q;
      assign xbm  = stg[k-1].g_rem.bm_q;
      assign s_nx = {slice[BLOCK-1:0], stg[k-1].s_q};
    end

    assign slice = cla_slice(xa[BLOCK-1:0], xb[BLOCK-1:0], xc);

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        s_q <= '0;
        c_q <= 1'b0;
      end else if (en) begin
        v_q <= xv;
        s_q <= s_nx;
        c_q <= slice[BLOCK];
      end
    end

    if (k < NSTG - 1) begin : g_rem
      logic [RW-BLOCK-1:0] ra_q, rb_q;
      logic                am_q, bm_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          ra_q <= '0;
          rb_q <= '0;
          am_q <= 1'b0;
          bm_q <= 1'b0;
        end else if (en) begin
          ra_q <= xa[RW-1:BLOCK];
          rb_q <= xb[RW-1:BLOCK];
          am_q <= xam;
          bm_q <= xbm;
        end
      end
    end else begin : g_last
      // The top slice holds the result MSB, so the sign test is made right here.
      logic ovf_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= (xam == xbm) && (slice[BLOCK-1] != xam);
        end
      end
    end
  end

  assign out_valid = stg[NSTG-1].v_q;
  assign sum       = stg[NSTG-1].s_q;
  assign cout      = stg[NSTG-1].c_q;
  assign ovf       = stg[NSTG-1].g_last.ovf_q;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Directed bench for cla_adder_pipe: default 64/16 instance driven through a scoreboard,
// plus a 32/8 instance checked directly.
module tb_cla_adder_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [63:0] a, b, sum;

  logic        in_valid2, in_ready2, cin2, out_valid2, out_ready2, cout2, ovf2;
  logic [31:0] a2, b2, sum2;

  cla_adder_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
  );

  cla_adder_pipe #(.WIDTH(32), .BLOCK(8)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
    .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2), .sum(sum2), .cout(cout2),
    .ovf(ovf2)
  );

  logic [65:0] exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference result packed as {cout, ovf, sum}.
  function automatic logic [65:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input logic c);
    logic [64:0] t;
    logic        v;
    t = {1'b0, x} + {1'b0, y} + {64'd0, c};
    v = (x[63] == y[63]) && (t[63] != x[63]);
    return {t[64], v, t[63:0]};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [63:0] xa, input logic [63:0] xb, input logic xc,
                      input bit push);
    bit acc;
    acc      = 1'b0;
    a        = xa;
    b        = xb;
    cin      = xc;
    in_valid = 1'b1;
    for (int n = 0; n < 64 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (!acc) out_ready = 1'b1;
    end
    in_valid = 1'b0;
    chk("accept", {127'd0, acc}, 128'd1);
    if (acc && push) exp_q.push_back(model(xa, xb, xc));
  endtask

  task automatic lat_check(input string tag);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk(tag, {127'd0, out_valid}, {127'd0, (i == 4)});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int n = 0; n < 64 && exp_q.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic monitor();
    logic        hold_chk;
    logic [65:0] held, e;
    hold_chk = 1'b0;
    held     = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_chk = 1'b0;
      end else begin
        chk("in_ready", {127'd0, in_ready}, {127'd0, !(out_valid && !out_ready)});
        if (hold_chk) chk("stall_hold", {cout, ovf, sum}, held);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_out", {127'd0, out_valid}, 128'd0);
          end else begin
            e = exp_q.pop_front();
            chk("result", {cout, ovf, sum}, e);
          end
        end
        hold_chk = out_valid && !out_ready;
        held     = {cout, ovf, sum};
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    cin        = 1'b0;
    out_ready  = 1'b1;
    in_valid2  = 1'b0;
    a2         = '0;
    b2         = '0;
    cin2       = 1'b0;
    out_ready2 = 1'b1;
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
    chk("rst_sum", {64'd0, sum}, 128'd0);
    chk("rst_cout_ovf", {126'd0, cout, ovf}, 128'd0);
    chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
    chk("rst_out_valid2", {127'd0, out_valid2}, 128'd0);
    chk("rst_sum2", {96'd0, sum2}, 128'd0);
    @(posedge clk);
    #1;

    send(64'd20, 64'd55, 1'b0, 1'b1);
    lat_check("lat_basic");
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b1);
    lat_check("lat_ripple");
    send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b1);
    lat_check("lat_ovf_pos");
    send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    lat_check("lat_ovf_neg");

    // Back-to-back stream, then hold the consumer off for 3 cycles.
    send(64'd24, 64'd133, 1'b1, 1'b1);
    send(64'd3748, 64'd9786, 1'b0, 1'b1);
    send(64'd655675, 64'd7374670, 1'b1, 1'b1);
    send(64'd4223372036854775808, 64'd28701384792384, 1'b1, 1'b1);
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
      chk("bp_out_valid", {127'd0, out_valid}, 128'd1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    drain();

    // Reset with three ops in flight: none may come out.
    send(64'd100, 64'd200, 1'b0, 1'b0);
    send(64'd300, 64'd400, 1'b1, 1'b0);
    send(64'd500, 64'd600, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rst_flush", {127'd0, out_valid}, 128'd0);
    end
    @(posedge clk);
    #1;
    send(64'd1, 64'd1, 1'b0, 1'b1);
    lat_check("lat_after_rst");
    drain();

    // Random stream with random consumer backpressure.
    for (int i = 0; i < 16; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      send({$urandom(), $urandom()}, {$urandom(), $urandom()}, 1'($urandom_range(0, 1)), 1'b1);
    end
    out_ready = 1'b1;
    drain();

    // 32-bit / 8-bit-slice instance.
    a2        = 32'hFFFF_0000;
    b2        = 32'h0001_0000;
    cin2      = 1'b0;
    in_valid2 = 1'b1;
    @(negedge clk);
    chk("w32_in_ready", {127'd0, in_ready2}, 128'd1);
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("w32_latency", {127'd0, out_valid2}, {127'd0, (i == 4)});
      if (i == 4) chk("w32_result", {94'd0, cout2, ovf2, sum2}, {94'd0, 1'b1, 1'b0, 32'd0});
    end

    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
